// File: rtl/dft_resp_pkg.sv
// Shared types and sizing helpers for the DFT-port scan responders.
package dft_resp_pkg;

  localparam int unsigned C_WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Number of packed words needed to carry a chain of len bits.
  function automatic int unsigned c_nwords(input int unsigned len);
    return (len + C_WORD_W - 1) / C_WORD_W;
  endfunction

  // Counter width able to hold the values 0..len inclusive.
  function automatic int unsigned c_cnt_w(input int unsigned len);
    return (len < 1) ? 1 : $clog2(len + 1);
  endfunction

endpackage

// File: rtl/scan_word_packer.sv
// Serial-to-parallel packer: collects sampled chain bits LSB-first into
// 32-bit words and presents each completed word with a one-cycle strobe.
module scan_word_packer
  import dft_resp_pkg::*;
#(
  parameter int unsigned P_CHAIN_LEN = 100
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_i,
  input  logic                bit_i,
  input  logic                clear_i,
  output logic [C_WORD_W-1:0] word_o,
  output logic                strobe_o,
  output logic                last_c_o
);

  localparam int unsigned C_CNT_W = c_cnt_w(P_CHAIN_LEN);
  localparam int unsigned C_POS_W = $clog2(C_WORD_W);

  logic [C_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [C_WORD_W-1:0] pack_q, pack_d;
  logic [C_WORD_W-1:0] word_q, word_d;
  logic [C_WORD_W-1:0] pack_with_bit;
  logic                strobe_q, strobe_d;
  logic [C_POS_W-1:0]  pos;
  logic                word_done;

  assign pos       = C_POS_W'(bit_cnt_q);
  assign last_c_o  = sample_i && (bit_cnt_q == C_CNT_W'(P_CHAIN_LEN - 1));
  assign word_done = sample_i && ((pos == C_POS_W'(C_WORD_W - 1)) || last_c_o);

  // Pack register is zeroed after every word, so a short final word is zero-padded.
  always_comb begin
    pack_with_bit      = pack_q;
    pack_with_bit[pos] = bit_i;
    bit_cnt_d          = bit_cnt_q;
    pack_d             = pack_q;
    word_d             = word_q;
    strobe_d           = 1'b0;
    if (clear_i) begin
      bit_cnt_d = '0;
      pack_d    = '0;
    end else if (sample_i) begin
      bit_cnt_d = bit_cnt_q + C_CNT_W'(1);
      pack_d    = word_done ? '0 : pack_with_bit;
      if (word_done) begin
        word_d   = pack_with_bit;
        strobe_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_q <= '0;
      pack_q    <= '0;
      word_q    <= '0;
      strobe_q  <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      pack_q    <= pack_d;
      word_q    <= word_d;
      strobe_q  <= strobe_d;
    end
  end

  assign word_o   = word_q;
  assign strobe_o = strobe_q;

endmodule

// File: rtl/dft_scan_unload_responder.sv
// Per-chain DFT unload responder: accepts an unload op, shifts the chain out
// into packed 32-bit words, then holds a commit until the prewrapper acks it.
module dft_scan_unload_responder
  import dft_resp_pkg::*;
#(
  parameter int unsigned P_CHAIN_LEN = 100,
  parameter bit          P_ROTATE    = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                dft_val_op,
  output logic                dft_op_ack,
  output logic [C_WORD_W-1:0] dft_output_data,
  output logic                dft_output_strobe,
  output logic                dft_op_commit,
  input  logic                dft_commit_ack,
  output logic                scan_en,
  input  logic                scan_so,
  output logic                scan_si,
  output logic                busy
);

  state_e state_q;
  logic   sample_c;
  logic   clear_c;
  logic   last_c;

  assign sample_c = (state_q == ST_SHIFT) && scan_en;
  assign clear_c  = (state_q == ST_COMMIT) && dft_commit_ack;
  assign scan_si  = P_ROTATE ? scan_so : 1'b0;

  scan_word_packer #(
    .P_CHAIN_LEN(P_CHAIN_LEN)
  ) u_packer (
    .clk      (clk),
    .reset    (reset),
    .sample_i (sample_c),
    .bit_i    (scan_so),
    .clear_i  (clear_c),
    .word_o   (dft_output_data),
    .strobe_o (dft_output_strobe),
    .last_c_o (last_c)
  );

  // SHIFT lingers one cycle with scan_en low so the last strobe precedes the commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      dft_op_ack    <= 1'b0;
      dft_op_commit <= 1'b0;
      scan_en       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      dft_op_ack <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (dft_val_op) begin
            state_q    <= ST_SHIFT;
            dft_op_ack <= 1'b1;
            scan_en    <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (last_c) begin
            scan_en <= 1'b0;
          end else if (!scan_en) begin
            state_q       <= ST_COMMIT;
            dft_op_commit <= 1'b1;
          end
        end
        ST_COMMIT: begin
          if (dft_commit_ack) begin
            state_q       <= ST_IDLE;
            dft_op_commit <= 1'b0;
            busy          <= 1'b0;
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          dft_op_commit <= 1'b0;
          scan_en       <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dft_scan_unload_responder.sv
// Bench for dft_scan_unload_responder: four instances (100/rotate, 100/no-rotate,
// 64, 1) with behavioural scan chains and a strobe scoreboard.
module tb_dft_scan_unload_responder;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       val_op;
  logic [3:0]       commit_ack;
  logic [3:0]       op_ack, strobe, commit, scan_en, scan_so, scan_si, busy;
  logic [3:0][31:0] data;

  logic [99:0] chain0, chain1;
  logic [63:0] chain2;
  logic        chain3;
  logic [99:0] ld_pat;
  logic [3:0]  ld_req = 4'b0;
  logic [99:0] alt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t0       = 0;
  int act      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dft_scan_unload_responder #(.P_CHAIN_LEN(100), .P_ROTATE(1'b1)) u0 (
    .clk(clk), .reset(reset), .dft_val_op(val_op[0]), .dft_op_ack(op_ack[0]),
    .dft_output_data(data[0]), .dft_output_strobe(strobe[0]), .dft_op_commit(commit[0]),
    .dft_commit_ack(commit_ack[0]), .scan_en(scan_en[0]), .scan_so(scan_so[0]),
    .scan_si(scan_si[0]), .busy(busy[0]));
  dft_scan_unload_responder #(.P_CHAIN_LEN(100), .P_ROTATE(1'b0)) u1 (
    .clk(clk), .reset(reset), .dft_val_op(val_op[1]), .dft_op_ack(op_ack[1]),
    .dft_output_data(data[1]), .dft_output_strobe(strobe[1]), .dft_op_commit(commit[1]),
    .dft_commit_ack(commit_ack[1]), .scan_en(scan_en[1]), .scan_so(scan_so[1]),
    .scan_si(scan_si[1]), .busy(busy[1]));
  dft_scan_unload_responder #(.P_CHAIN_LEN(64), .P_ROTATE(1'b1)) u2 (
    .clk(clk), .reset(reset), .dft_val_op(val_op[2]), .dft_op_ack(op_ack[2]),
    .dft_output_data(data[2]), .dft_output_strobe(strobe[2]), .dft_op_commit(commit[2]),
    .dft_commit_ack(commit_ack[2]), .scan_en(scan_en[2]), .scan_so(scan_so[2]),
    .scan_si(scan_si[2]), .busy(busy[2]));
  dft_scan_unload_responder #(.P_CHAIN_LEN(1), .P_ROTATE(1'b1)) u3 (
    .clk(clk), .reset(reset), .dft_val_op(val_op[3]), .dft_op_ack(op_ack[3]),
    .dft_output_data(data[3]), .dft_output_strobe(strobe[3]), .dft_op_commit(commit[3]),
    .dft_commit_ack(commit_ack[3]), .scan_en(scan_en[3]), .scan_so(scan_so[3]),
    .scan_si(scan_si[3]), .busy(busy[3]));

  // Behavioural chains: bit 0 is nearest scan_so, scan_si enters at the top.
  assign scan_so = {chain3, chain2[0], chain1[0], chain0[0]};
  always @(posedge clk) begin
    if (ld_req[0]) chain0 <= ld_pat;
    else if (scan_en[0]) chain0 <= {scan_si[0], chain0[99:1]};
    if (ld_req[1]) chain1 <= ld_pat;
    else if (scan_en[1]) chain1 <= {scan_si[1], chain1[99:1]};
    if (ld_req[2]) chain2 <= ld_pat[63:0];
    else if (scan_en[2]) chain2 <= {scan_si[2], chain2[63:1]};
    if (ld_req[3]) chain3 <= ld_pat[0];
    else if (scan_en[3]) chain3 <= scan_si[3];
  end

  // Scoreboard: every strobe of the active instance must match the next expected word and cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if ((strobe & ~4'(1 << act)) != 4'b0) begin
        checks++;
        failures++;
        $display("FAIL stray_strobe strobes=%b active=%0d", strobe, act);
      end
      if (strobe[act]) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL strobe_unexpected inst=%0d cycle=%0d data=%h required=no strobe",
                   act, cyc - t0, data[act]);
        end else begin
          mon_e = exp_q.pop_front();
          if (data[act] !== mon_e.data || (cyc - t0) != mon_e.cyc) begin
            failures++;
            $display("FAIL strobe_word inst=%0d data=%h cycle=%0d required data=%h cycle=%0d",
                     act, data[act], cyc - t0, mon_e.data, mon_e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d required=finish", cyc);
    $fatal(1);
  end

  task automatic load_chain(input int i, input logic [99:0] pat);
    @(negedge clk);
    ld_pat    = pat;
    ld_req[i] = 1'b1;
    @(negedge clk);
    ld_req[i] = 1'b0;
  endtask

  task automatic push_one(input logic [31:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic push_alt100();
    push_one(32'hAAAAAAAA, 33);
    push_one(32'hAAAAAAAA, 65);
    push_one(32'hAAAAAAAA, 97);
    push_one(32'h0000000A, 101);
  endtask

  task automatic push_exp(input logic [99:0] pat, input int len);
    int   nw;
    logic [31:0] w;
    nw = (len + 31) / 32;
    for (int k = 0; k < nw; k++) begin
      w = '0;
      for (int j = 0; j < 32; j++)
        if (32 * k + j < len) w[j] = pat[32 * k + j];
      push_one(w, ((32 * (k + 1) < len) ? 32 * (k + 1) : len) + 1);
    end
  endtask

  // Returns at the negedge of cycle 1 (the first cycle after the accepting edge).
  task automatic start_op(input int i, input bit hold);
    act = i;
    @(negedge clk);
    val_op[i] = 1'b1;
    t0 = cyc;
    @(negedge clk);
    if (!hold) val_op[i] = 1'b0;
  endtask

  task automatic wait_commit(input int i, output int idx);
    idx = -1;
    for (int n = 0; n < 300 && idx < 0; n++) begin
      if (commit[i]) idx = cyc - t0;
      else @(negedge clk);
    end
  endtask

  task automatic ack_commit(input int i);
    commit_ack[i] = 1'b1;
    @(negedge clk);
    commit_ack[i] = 1'b0;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    val_op     = 4'b0;
    commit_ack = 4'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({op_ack, strobe, commit, scan_en, busy} !== 20'b0) begin
      failures++;
      $display("FAIL reset_ctrl ack=%b strobe=%b commit=%b scan_en=%b busy=%b required all 0",
               op_ack, strobe, commit, scan_en, busy);
    end
    checks++;
    if (data !== '0) begin
      failures++;
      $display("FAIL reset_data data=%h required=0", data);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unload_basic();
    int idx;
    load_chain(0, alt);
    push_alt100();
    start_op(0, 1'b0);
    checks++;
    if (op_ack[0] !== 1'b1 || scan_en[0] !== 1'b1 || busy[0] !== 1'b1) begin
      failures++;
      $display("FAIL ack_cycle1 ack=%b scan_en=%b busy=%b required 1/1/1",
               op_ack[0], scan_en[0], busy[0]);
    end
    @(negedge clk);
    checks++;
    if (op_ack[0] !== 1'b0) begin
      failures++;
      $display("FAIL ack_one_cycle ack=%b required=0", op_ack[0]);
    end
    while (cyc - t0 < 100) @(negedge clk);
    checks++;
    if (scan_en[0] !== 1'b1) begin
      failures++;
      $display("FAIL scan_en_last_shift scan_en=%b required=1", scan_en[0]);
    end
    @(negedge clk);
    checks++;
    if (scan_en[0] !== 1'b0 || commit[0] !== 1'b0) begin
      failures++;
      $display("FAIL scan_en_drop scan_en=%b commit=%b required 0/0", scan_en[0], commit[0]);
    end
    wait_commit(0, idx);
    checks++;
    if (idx != 102) begin
      failures++;
      $display("FAIL commit_cycle cycle=%0d required=102", idx);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL words_missing left=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_commit_hold();
    bit ok = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (commit[0] !== 1'b1 || busy[0] !== 1'b1) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL commit_hold commit=%b busy=%b required held 1", commit[0], busy[0]);
    end
    ack_commit(0);
    checks++;
    if (commit[0] !== 1'b0 || busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL commit_release commit=%b busy=%b required 0/0", commit[0], busy[0]);
    end
  endtask

  task automatic test_rotate();
    int idx;
    checks++;
    if (chain0 !== alt) begin
      failures++;
      $display("FAIL rotate_restore chain=%h required=%h", chain0, alt);
    end
    push_alt100();
    start_op(0, 1'b0);
    wait_commit(0, idx);
    ack_commit(0);
    checks++;
    if (idx != 102 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL rotate_second_unload commit_cycle=%0d left=%0d required 102/0", idx, exp_q.size());
    end
    load_chain(1, alt);
    push_alt100();
    start_op(1, 1'b0);
    wait_commit(1, idx);
    ack_commit(1);
    for (int k = 0; k < 3; k++) push_one(32'h0, 32 * (k + 1) + 1);
    push_one(32'h0, 101);
    start_op(1, 1'b0);
    wait_commit(1, idx);
    ack_commit(1);
    checks++;
    if (idx != 102 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL destructive_unload commit_cycle=%0d left=%0d required 102/0", idx, exp_q.size());
    end
  endtask

  task automatic test_val_op_hold();
    int nack;
    int idx;
    bit done = 1'b0;
    push_alt100();
    start_op(0, 1'b1);
    nack = op_ack[0] ? 1 : 0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (op_ack[0]) nack++;
      if (commit[0]) done = 1'b1;
      else if (cyc - t0 > 10) val_op[0] = 1'($urandom_range(0, 1));
    end
    for (int n = 0; n < 4; n++) begin
      val_op[0] = ~val_op[0];
      @(negedge clk);
      if (op_ack[0]) nack++;
    end
    val_op[0] = 1'b1;
    push_alt100();
    commit_ack[0] = 1'b1;
    @(negedge clk);
    commit_ack[0] = 1'b0;
    t0 = cyc;
    checks++;
    if (!done || nack != 1 || op_ack[0] !== 1'b0 || busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL hold_single_ack done=%0d acks=%0d ack=%b busy=%b required 1/1/0/0",
               done, nack, op_ack[0], busy[0]);
    end
    @(negedge clk);
    val_op[0] = 1'b0;
    checks++;
    if (op_ack[0] !== 1'b1) begin
      failures++;
      $display("FAIL hold_reaccept ack=%b required=1", op_ack[0]);
    end
    wait_commit(0, idx);
    ack_commit(0);
    checks++;
    if (idx != 102 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL hold_second_op commit_cycle=%0d left=%0d required 102/0", idx, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    int idx;
    load_chain(0, alt);
    push_alt100();
    start_op(0, 1'b0);
    while (cyc - t0 < 50) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (scan_en[0] !== 1'b0 || busy[0] !== 1'b0 || data[0] !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid scan_en=%b busy=%b data=%h required 0/0/0", scan_en[0], busy[0], data[0]);
    end
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 150; n++) begin
      @(negedge clk);
      if (strobe[0] || commit[0] || busy[0]) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL reset_mid_quiet activity=1 required=0");
    end
    load_chain(0, alt);
    push_alt100();
    start_op(0, 1'b0);
    wait_commit(0, idx);
    ack_commit(0);
    checks++;
    if (idx != 102 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL reset_mid_fresh commit_cycle=%0d left=%0d required 102/0", idx, exp_q.size());
    end
  endtask

  task automatic test_short_chains();
    logic [99:0] p;
    int idx;
    p         = '0;
    p[31:0]   = $urandom;
    p[63:32]  = $urandom;
    load_chain(2, p);
    push_exp(p, 64);
    start_op(2, 1'b0);
    wait_commit(2, idx);
    checks++;
    if (idx != 66 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL len64 commit_cycle=%0d left=%0d required 66/0", idx, exp_q.size());
    end
    ack_commit(2);
    checks++;
    if (commit[2] !== 1'b0 || busy[2] !== 1'b0 || chain2 !== p[63:0]) begin
      failures++;
      $display("FAIL len64_end commit=%b busy=%b chain=%h required 0/0/%h",
               commit[2], busy[2], chain2, p[63:0]);
    end
    p = '0;
    p[0] = 1'b1;
    load_chain(3, p);
    push_one(32'h00000001, 2);
    start_op(3, 1'b0);
    checks++;
    if (op_ack[3] !== 1'b1 || scan_en[3] !== 1'b1) begin
      failures++;
      $display("FAIL len1_ack ack=%b scan_en=%b required 1/1", op_ack[3], scan_en[3]);
    end
    wait_commit(3, idx);
    checks++;
    if (idx != 3 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL len1 commit_cycle=%0d left=%0d required 3/0", idx, exp_q.size());
    end
    ack_commit(3);
  endtask

  initial begin
    for (int i = 0; i < 100; i++) alt[i] = 1'(i % 2);
    test_reset();
    test_unload_basic();
    test_commit_hold();
    test_rotate();
    test_val_op_hold();
    test_reset_mid();
    test_short_chains();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
